// File: rtl/aes_key_expansion_if.sv
// Request/response bundle between the AES-128 key schedule and its consumer.
// With AES_KEY_EXP_LAST_KEY_EN defined the bundle also carries last_round_key.
interface aes_key_expansion_if #(
  parameter int BLOCK_LENGTH = 128
);
  logic                    start;
  logic [BLOCK_LENGTH-1:0] cipher_key;
  logic                    key_next;
  logic [BLOCK_LENGTH-1:0] round_key;
  logic [3:0]              round_num;
  logic                    key_valid;
  logic                    done;
`ifdef AES_KEY_EXP_LAST_KEY_EN
  logic [BLOCK_LENGTH-1:0] last_round_key;

  modport master (
    output start, cipher_key, key_next,
    input  round_key, round_num, key_valid, done, last_round_key
  );
  modport slave (
    input  start, cipher_key, key_next,
    output round_key, round_num, key_valid, done, last_round_key
  );
`else
  modport master (
    output start, cipher_key, key_next,
    input  round_key, round_num, key_valid, done
  );
  modport slave (
    input  start, cipher_key, key_next,
    output round_key, round_num, key_valid, done
  );
`endif
endinterface

// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per advance, rounds 0..NUM_ROUNDS.
// Optional AES_KEY_EXP_LAST_KEY_EN keeps a copy of the final round key.
module aes_key_expansion #(
  parameter int BLOCK_LENGTH = 128,
  parameter int NUM_ROUNDS   = 10
) (
  input logic                 clk,
  input logic                 rst_n,
  aes_key_expansion_if.slave  bus
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [3:0] PRE_LAST   = 4'(NUM_ROUNDS - 1);

  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  // Entry 0 sits in the most significant byte, hence the reversed index.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8'd255 - x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] n0;
    logic [31:0] n1;
    logic [31:0] n2;
    logic [31:0] n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  state_e                  state_q, state_d;
  logic [BLOCK_LENGTH-1:0] round_key_q, round_key_d;
  logic [3:0]              round_num_q, round_num_d;
  logic [7:0]              rcon_q, rcon_d;
  logic                    key_valid_q, key_valid_d;
  logic                    done_q, done_d;
  logic [BLOCK_LENGTH-1:0] next_key_s;
`ifdef AES_KEY_EXP_LAST_KEY_EN
  logic [BLOCK_LENGTH-1:0] last_key_q, last_key_d;
`endif

  assign next_key_s = expand(round_key_q, rcon_q);

  // Next-state: start overrides everything, then advance or retire the schedule.
  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_num_d = round_num_q;
    rcon_d      = rcon_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
`ifdef AES_KEY_EXP_LAST_KEY_EN
    last_key_d  = last_key_q;
`endif
    if (bus.start) begin
      state_d     = ACTIVE;
      round_key_d = bus.cipher_key;
      round_num_d = 4'd0;
      rcon_d      = 8'h01;
      key_valid_d = 1'b1;
`ifdef AES_KEY_EXP_LAST_KEY_EN
      last_key_d  = {BLOCK_LENGTH{1'b0}};
`endif
    end else begin
      case (state_q)
        ACTIVE: begin
          if (bus.key_next) begin
            if (round_num_q < LAST_ROUND) begin
              round_key_d = next_key_s;
              round_num_d = round_num_q + 4'd1;
              rcon_d      = xtime(rcon_q);
              done_d      = (round_num_q == PRE_LAST);
`ifdef AES_KEY_EXP_LAST_KEY_EN
              if (round_num_q == PRE_LAST) begin
                last_key_d = next_key_s;
              end else begin
                last_key_d = last_key_q;
              end
`endif
            end else begin
              // Final key consumed: drop valid but keep key/index visible.
              state_d     = IDLE;
              key_valid_d = 1'b0;
            end
          end else begin
            state_d = ACTIVE;
          end
        end
        IDLE: begin
          state_d = IDLE;
        end
        default: begin
          state_d     = IDLE;
          key_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      round_key_q <= {BLOCK_LENGTH{1'b0}};
      round_num_q <= 4'd0;
      rcon_q      <= 8'h01;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_KEY_EXP_LAST_KEY_EN
      last_key_q  <= {BLOCK_LENGTH{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_num_q <= round_num_d;
      rcon_q      <= rcon_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
`ifdef AES_KEY_EXP_LAST_KEY_EN
      last_key_q  <= last_key_d;
`endif
    end
  end

  assign bus.round_key = round_key_q;
  assign bus.round_num = round_num_q;
  assign bus.key_valid = key_valid_q;
  assign bus.done      = done_q;
`ifdef AES_KEY_EXP_LAST_KEY_EN
  assign bus.last_round_key = last_key_q;
`endif

endmodule
